// File: rtl/seq_mul_handshake.sv
// seq_mul_handshake: radix-2 shift-add unsigned multiplier, one WIDTH+1 bit adder reused
// for WIDTH cycles, with valid/ready handshakes on operand and result sides.
module seq_mul_handshake #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH:0]   hi, sum;
    logic [WIDTH-1:0] lo, a_reg;
    logic [CW-1:0]    cnt;
    logic             accept, zero_op, last;
    assign accept  = in_valid && state == IDLE;
    assign zero_op = a == '0 || b == '0;
    assign last    = cnt == CW'(WIDTH - 1);
    assign sum     = hi + (lo[0] ? {1'b0, a_reg} : '0);
    always_comb begin
        state_nxt = state;
        in_ready  = state == IDLE;
        busy      = state != IDLE;
        out_valid = state == DONE;
        case (state)
            IDLE:    state_nxt = accept ? (zero_op ? DONE : RUN) : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            hi      <= '0;
            lo      <= '0;
            a_reg   <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_reg <= a;
                hi    <= '0;
                lo    <= b;
                cnt   <= '0;
                if (zero_op) product <= '0;
            end else if (state == RUN) begin
                // The carry lands in sum[WIDTH] and is shifted down into hi.
                hi  <= {1'b0, sum[WIDTH:1]};
                lo  <= {sum[0], lo[WIDTH-1:1]};
                cnt <= cnt + 1'b1;
                if (last) product <= {sum, lo[WIDTH-1:1]};
            end
        end
    end
endmodule

// File: tb/tb_seq_mul_handshake.sv
// tb_seq_mul_handshake: directed and randomized checks of seq_mul_handshake against a
// transaction-level model (product = a*b, result after a fixed countdown).
module tb_seq_mul_handshake;
    localparam int W  = 16;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          in_ready, out_valid, busy;
    logic [PW-1:0] product;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    seq_mul_handshake #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Model: idle until accepted, then the result appears after W edges (or at once
    // for a zero operand) and stays until out_ready is seen.
    bit            m_idle = 1'b1;
    bit            m_valid = 1'b0;
    int            m_left = 0;
    logic [PW-1:0] m_pend = '0;
    logic [PW-1:0] m_out = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle  <= 1'b1;
            m_valid <= 1'b0;
            m_left  <= 0;
            m_out   <= '0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle <= 1'b0;
                m_pend <= PW'(a) * PW'(b);
                if (a == 0 || b == 0) begin
                    m_valid <= 1'b1;
                    m_out   <= '0;
                end else m_left <= W;
            end
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid <= 1'b0;
                m_idle  <= 1'b1;
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_valid <= 1'b1;
                m_out   <= m_pend;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("in_ready", in_ready, m_idle);
            chk("busy", busy, !m_idle);
            chk("out_valid", out_valid, m_valid);
            chk("product", product, m_out);
        end
    end

    function automatic logic [W-1:0] rop();
        int r = $urandom % 8;
        return r == 0 ? '0 : r == 1 ? '1 : W'($urandom);
    endfunction

    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic [PW-1:0] exp,
                         input int exp_lat, input int hold, input bit churn);
        int n;
        bit seen;
        @(negedge clk);
        a = oa;
        b = ob;
        in_valid = 1'b1;
        out_ready = hold == 0;
        chk("pre_in_ready", in_ready, 1);
        @(posedge clk);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            seen = out_valid;
            if (seen || !churn) in_valid = 1'b0;
            if (churn && !seen) begin
                a = W'($urandom);
                b = W'($urandom);
            end
        end
        chk("latency", n, exp_lat);
        chk("result", product, exp);
        chk("model_result", m_out, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_product", product, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("valid_dropped", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
        chk("busy_clear", busy, 0);
        chk("product_kept", product, exp);
    endtask

    initial begin
        int g;
        repeat (3) @(negedge clk);
        chk("rst_product", product, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        chk_en = 1'b1;

        do_op(16'd3, 16'd5, 32'h0000_000F, 17, 0, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 17, 0, 1'b0);
        do_op(16'h8000, 16'h0002, 32'h0001_0000, 17, 0, 1'b0);
        do_op(16'h1234, 16'h0000, 32'h0, 1, 0, 1'b0);
        do_op(16'h0000, 16'hFFFF, 32'h0, 1, 0, 1'b0);
        do_op(16'h00FF, 16'h0101, 32'h0000_FFFF, 17, 5, 1'b0);

        // Reset in the middle of RUN, between clock edges.
        @(negedge clk);
        a = 16'd7;
        b = 16'd9;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_product", product, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_spurious", out_valid, 0);
        end
        do_op(16'd2, 16'd2, 32'd4, 17, 0, 1'b0);
        do_op(16'h0100, 16'h0300, 32'h0003_0000, 17, 0, 1'b1);

        // Back-to-back random pairs; operands keep changing while busy.
        for (int i = 0; i < 1000; i++) begin
            a = rop();
            b = rop();
            in_valid = 1'b1;
            g = 0;
            while (!in_ready && g < 200) begin
                out_ready = ($urandom % 4) != 0;
                @(negedge clk);
                g++;
            end
            chk("accept_wait_bound", g < 200, 1);
            if (g >= 200) break;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        g = 0;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("final_idle", in_ready, 1);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_mul_handshake.md
Name: seq_mul_handshake

Overview:
- Multi-cycle radix-2 shift-add unsigned multiplier with valid/ready handshakes on both operand and result sides.
- Performs the forward operation for the quotient-only divider datapath, so divide results can be checked and rebuilt (Q*D) without a large combinational multiplier array.
- Uses one adder of WIDTH+1 bits, reused for WIDTH iterations.
- Sits between the operand register file and the result writeback stage.

Parameters:
- WIDTH, 16, operand width in bits; product is 2*WIDTH bits; legal range 4..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b present.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product valid; held until accepted.
- out_ready  input  1  downstream accepts product.
- product  output  2*WIDTH  a*b, unsigned.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: one clock, asynchronous active-low reset. Assertion of rst_n=0 at any time, including mid-RUN or mid-DONE, immediately forces the following:
  - state=IDLE
  - in_ready=1 once rst_n deasserts
  - out_valid=0, product=0, busy=0
  - internal hi/lo/a registers and counter = 0
  - any in-flight operation is discarded; no partial result is ever presented.
- State machine: IDLE, RUN, DONE.
  - IDLE:
    - in_ready=1.
    - On in_valid&in_ready, capture a into a_reg.
    - If a==0 or b==0: go to DONE with product=0 (zero shortcut).
    - Else: hi=0 (WIDTH+1 bits), lo=b, cnt=0, go to RUN.
  - RUN, one iteration per cycle:
    - sum = hi + (lo[0] ? {1'b0,a_reg} : 0), computed WIDTH+1 bits wide with no truncation.
    - {hi,lo} = {sum,lo} >> 1, i.e. hi = sum >> 1 and lo = {sum[0], lo[WIDTH-1:1]}.
    - cnt increments.
    - After the WIDTH-th iteration (cnt==WIDTH-1 at the edge), go to DONE with product = {hi[WIDTH-1:0], lo} as registered.
  - DONE:
    - out_valid=1; product is stable and unchanged while out_valid=1 and out_ready=0.
    - On out_valid&out_ready, go to IDLE. out_valid drops the next cycle; product retains its last value.
- Latency, measured from the accept edge to the first cycle out_valid=1:
  - nonzero operands: WIDTH+1 cycles (17 for WIDTH=16).
  - zero shortcut: 1 cycle.
- Throughput: no overlap. in_ready returns high the cycle after result acceptance. The minimum accept-to-accept interval is WIDTH+2 cycles with out_ready tied high.
- Operand capture:
  - a and b are sampled only on the accept edge.
  - Changes on a/b/in_valid during RUN/DONE are ignored; in_ready=0 there, so no accept can occur.
  - in_valid high while busy is not an error and is not queued.
- Simultaneous events:
  - out_ready high before DONE has no effect.
  - In DONE, an out handshake and in_valid=1 in the same cycle: the in handshake does not occur, because in_ready=0 in DONE.
- Width rules:
  - Full product 2*WIDTH bits, never truncated; max 0xFFFF*0xFFFF = 0xFFFE0001 fits.
  - The carry out of the add is kept in hi[WIDTH] and shifted down each cycle.
- busy = (state != IDLE); in_ready = (state == IDLE).

Test Plan:
- Basic multiply, WIDTH=16, out_ready=1: accept a=3, b=5. Require:
  - out_valid rises exactly 17 cycles after the accept edge with product=0x0000000F.
  - out_valid lasts 1 cycle.
  - in_ready rises the following cycle.
- Max operands: a=0xFFFF, b=0xFFFF -> product=0xFFFE0001. Also a=0x8000, b=0x0002 -> 0x00010000, confirming carry/shift handling.
- Zero shortcut:
  - a=0x1234, b=0 -> out_valid 1 cycle after accept, product=0.
  - a=0, b=0xFFFF -> same.
- Backpressure: a=0x00FF, b=0x0101 with out_ready=0 for 5 cycles in DONE. Require:
  - product=0x0000FFFF held stable and out_valid=1 throughout.
  - in_ready=0 throughout.
  - Release out_ready -> IDLE next cycle.
- Reset mid-operation: accept a=7, b=9, then drop rst_n asynchronously (between clock edges) at cycle 8 of RUN. Require:
  - out_valid=0, product=0 and busy=0 immediately, with no spurious result after release.
  - A subsequent a=2, b=2 -> 4 at nominal latency.
- Busy-time stimulus: hold in_valid=1 with changing a/b during RUN. Require:
  - no extra accepts.
  - result = product of the originally captured operands.
  - randomized back-to-back run of 1000 pairs vs reference model a*b.
